// File: rtl/threshold_pkg.sv
// Shared types and helpers for the threshold result merger: FSM states, colour modes,
// the round-robin grant search and the sample-to-colour mapping.
package threshold_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MODE_BINARY = 0;
    localparam int MODE_GREY   = 1;

    // Upper bound on channel count; grant indices and request vectors are sized to it.
    localparam int MAX_CH = 16;

    // First requesting channel at or above ptr, wrapping modulo num_ch (a power of two).
    // Returns ptr when nothing requests; the caller qualifies with |req.
    function automatic logic [3:0] rr_next(input logic [3:0] ptr,
                                           input logic [MAX_CH-1:0] req,
                                           input int num_ch);
        logic [3:0] idx;
        rr_next = ptr;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            idx = 4'((int'(ptr) + i) & (num_ch - 1));
            if (i < num_ch && req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

    // Samples up to 16 bits wide; grey mode takes the three most significant sample bits.
    function automatic logic [2:0] map_colour(input logic [15:0] data,
                                              input int data_bits,
                                              input int mode);
        if (mode == MODE_GREY && data_bits >= 3) begin
            map_colour = data[data_bits-1 -: 3];
        end else begin
            map_colour = {3{data[0]}};
        end
    endfunction

endpackage

// File: rtl/threshold_result_merger_fifo.sv
// Generic synchronous FIFO, 2^FIFO_DEPTH_BITS entries, first-word-fall-through read data.
// Latency: pushed word is visible on data the cycle after the push edge.
// Backpressure: full blocks push unless a pop happens on the same edge; pop on empty is ignored.
module result_fifo #(
    parameter int PAYLOAD_BITS    = 24,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                    clock,
    input  logic                    not_reset,
    input  logic                    push,
    input  logic [PAYLOAD_BITS-1:0] push_dat,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [PAYLOAD_BITS-1:0] data
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam logic [FIFO_DEPTH_BITS:0] FULL_CNT = DEPTH[FIFO_DEPTH_BITS:0];

    logic [PAYLOAD_BITS-1:0]    mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic                       do_push;
    logic                       do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/threshold_result_merger.sv
// Merges NUM_CH filter result streams into one framebuffer write port via per-channel FIFOs.
// Latency: 2 cycles push-to-oWren minimum (push edge, then pop/register edge); 1 pixel/cycle max.
// Backpressure: iChReady[k] drops when FIFO k is full or outside RUN; nothing is ever dropped.
module threshold_result_merger
    import threshold_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int WIDTH_BITS      = 8,
    parameter int HEIGHT_BITS     = 8,
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int MODE            = MODE_BINARY
) (
    input  logic                              clock,
    input  logic                              not_reset,
    input  logic                              iStart,
    input  logic [NUM_CH-1:0]                 iChValid,
    output logic [NUM_CH-1:0]                 iChReady,
    input  logic [NUM_CH*WIDTH_BITS-1:0]      iChCol,
    input  logic [NUM_CH*HEIGHT_BITS-1:0]     iChRow,
    input  logic [NUM_CH*DATA_BITS-1:0]       iChData,
    input  logic [NUM_CH-1:0]                 iChDone,
    output logic [WIDTH_BITS-1:0]             oX,
    output logic [HEIGHT_BITS-1:0]            oY,
    output logic [2:0]                        oR,
    output logic [2:0]                        oG,
    output logic [2:0]                        oB,
    output logic                              oWren,
    output logic [WIDTH_BITS+HEIGHT_BITS:0]   oPixelCount,
    output logic                              oBusy,
    output logic                              oDone
);

    localparam int CNT_BITS = WIDTH_BITS + HEIGHT_BITS + 1;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  col;
        logic [HEIGHT_BITS-1:0] row;
        logic [DATA_BITS-1:0]   data;
    } pix_t;

    localparam int PIX_BITS = $bits(pix_t);

    state_t              state_q;
    state_t              state_d;
    logic [NUM_CH-1:0]   sticky_q;
    logic [NUM_CH-1:0]   sticky_d;
    logic [3:0]          ptr_q;
    logic [3:0]          ptr_d;

    logic [NUM_CH-1:0]   fifo_full;
    logic [NUM_CH-1:0]   fifo_empty;
    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    pix_t                fifo_dat [NUM_CH];

    logic [MAX_CH-1:0]   req_ext;
    logic [3:0]          grant_idx;
    logic                grant_vld;
    pix_t                win;
    logic [2:0]          colour;
    logic                start_ok;

    assign iChReady = (state_q == RUN) ? ~fifo_full : '0;
    assign push     = iChValid & iChReady;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pix_t in_pix;
        assign in_pix = {iChCol[k*WIDTH_BITS +: WIDTH_BITS],
                         iChRow[k*HEIGHT_BITS +: HEIGHT_BITS],
                         iChData[k*DATA_BITS +: DATA_BITS]};

        result_fifo #(
            .PAYLOAD_BITS    (PIX_BITS),
            .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock     (clock),
            .not_reset (not_reset),
            .push      (push[k]),
            .push_dat  (in_pix),
            .pop       (pop[k]),
            .full      (fifo_full[k]),
            .empty     (fifo_empty[k]),
            .data      (fifo_dat[k])
        );
    end

    always_comb begin
        req_ext = '0;
        req_ext[NUM_CH-1:0] = ~fifo_empty;
    end

    assign grant_vld = |req_ext;
    assign grant_idx = rr_next(ptr_q, req_ext, NUM_CH);
    assign ptr_d     = grant_vld ? 4'((int'(grant_idx) + 1) & (NUM_CH - 1)) : ptr_q;

    always_comb begin
        pop = '0;
        win = fifo_dat[0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_vld && grant_idx == 4'(k)) begin
                pop[k] = 1'b1;
                win    = fifo_dat[k];
            end
        end
    end

    assign colour   = map_colour(16'(win.data), DATA_BITS, MODE);
    assign start_ok = iStart && (state_q == IDLE || state_q == DONE);

    // Done flags accumulate only in RUN; a push landing with the last done flag is still taken.
    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d  = RUN;
                    sticky_d = '0;
                end
            end
            RUN: begin
                sticky_d = sticky_q | iChDone;
                if (&sticky_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (&fifo_empty) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q  <= IDLE;
            sticky_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            ptr_q    <= ptr_d;
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            oX          <= '0;
            oY          <= '0;
            oR          <= '0;
            oG          <= '0;
            oB          <= '0;
            oWren       <= 1'b0;
            oPixelCount <= '0;
        end else begin
            oWren <= grant_vld;
            if (grant_vld) begin
                oX <= win.col;
                oY <= win.row;
                oR <= colour;
                oG <= colour;
                oB <= colour;
            end
            if (start_ok) begin
                oPixelCount <= '0;
            end else if (grant_vld && oPixelCount != '1) begin
                oPixelCount <= oPixelCount + CNT_BITS'(1);
            end
        end
    end

    assign oBusy = (state_q == RUN) || (state_q == DRAIN);
    assign oDone = (state_q == DONE);

endmodule
